// File: rtl/waveform_analyzer.sv
// Square-wave analyzer: measures period and high time of I_WAVE and recovers the
// 11-bit frequency code and 2-bit duty code that the channel generator was programmed with.
module waveform_analyzer #(
    parameter int unsigned PERIOD_W      = 24,
    parameter int unsigned CLKS_PER_UNIT = 763
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                I_WAVE,
    input  logic                I_MEASURE_EN,
    output logic [PERIOD_W-1:0] O_PERIOD,
    output logic [PERIOD_W-1:0] O_HIGH,
    output logic [1:0]          O_DUTY_CYCLE,
    output logic [10:0]         O_FREQUENCY,
    output logic                O_VALID,
    output logic                O_RANGE_ERR,
    output logic                O_TIMEOUT,
    output logic                O_OVERRUN
);

    localparam int unsigned DW   = PERIOD_W + 1;
    localparam int unsigned XW   = PERIOD_W + 5;
    localparam int unsigned SC_W = $clog2(DW + 1);

    localparam logic [DW:0]         DIVISOR   = (DW + 1)'(CLKS_PER_UNIT);
    localparam logic [DW-1:0]       HALF_UNIT = DW'(CLKS_PER_UNIT / 2);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [SC_W-1:0]     STEPS     = SC_W'(DW);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    // Input conditioning
    logic [1:0] sync_q;
    logic       prev_q;
    logic       wave_s, rise, fall;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], I_WAVE};
            prev_q <= sync_q[1];
        end
    end

    assign wave_s = sync_q[1];
    assign rise   = wave_s & ~prev_q;
    assign fall   = ~wave_s & prev_q;

    // Measurement FSM
    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] high_cnt_q, high_cnt_d;
    logic                high_open_q, high_open_d;
    logic                handoff, timeout;
    logic [PERIOD_W-1:0] meas_high;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_cnt_d  = high_cnt_q;
        high_open_d = high_open_q;
        handoff     = 1'b0;
        timeout     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (I_MEASURE_EN && rise) begin
                    state_d     = StMeasure;
                    cnt_d       = PERIOD_W'(1);
                    high_cnt_d  = '0;
                    high_open_d = 1'b1;
                end
            end
            StMeasure: begin
                cnt_d = cnt_q + PERIOD_W'(1);
                if (!I_MEASURE_EN) begin
                    state_d = StIdle;
                end else if (rise) begin
                    // Next period starts on the same cycle the current one closes
                    handoff     = 1'b1;
                    cnt_d       = PERIOD_W'(1);
                    high_cnt_d  = '0;
                    high_open_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else if (fall && high_open_q) begin
                    high_cnt_d  = cnt_q;
                    high_open_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            high_cnt_q  <= '0;
            high_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cnt_q  <= high_cnt_d;
            high_open_q <= high_open_d;
        end
    end

    // A period with no observed fall is treated as fully high
    assign meas_high = high_open_q ? cnt_q : high_cnt_q;

    // Duty classification against midpoints of 1/8, 2/8, 4/8, 6/8
    logic [XW-1:0] p_ext, h16, p3, p6, p10;
    logic [1:0]    duty_calc;

    always_comb begin
        p_ext = XW'(cnt_q);
        h16   = XW'(meas_high) << 4;
        p3    = (p_ext << 1) + p_ext;
        p6    = p3 << 1;
        p10   = (p_ext << 3) + (p_ext << 1);
        if (h16 < p3) begin
            duty_calc = 2'b00;
        end else if (h16 < p6) begin
            duty_calc = 2'b01;
        end else if (h16 < p10) begin
            duty_calc = 2'b10;
        end else begin
            duty_calc = 2'b11;
        end
    end

    // Restoring divider; quotient bits shift into the dividend register from the LSB
    logic                busy_q;
    logic [SC_W-1:0]     step_q;
    logic [DW-1:0]       dvd_q, rem_q;
    logic [PERIOD_W-1:0] pend_period_q, pend_high_q;
    logic [1:0]          pend_duty_q;

    logic [DW:0]   rem_shift;
    logic          q_bit;
    logic [DW-1:0] rem_next, quot_next;
    logic          done, accept, overrun, in_range;
    logic [31:0]   n_ext;
    logic [10:0]   freq_calc;

    always_comb begin
        rem_shift = {rem_q, dvd_q[DW-1]};
        q_bit     = (rem_shift >= DIVISOR);
        rem_next  = q_bit ? DW'(rem_shift - DIVISOR) : rem_shift[DW-1:0];
        quot_next = {dvd_q[DW-2:0], q_bit};
        done      = busy_q && (step_q == SC_W'(1));
        accept    = handoff && (!busy_q || done);
        overrun   = handoff && busy_q && !done;
        n_ext     = 32'(quot_next);
        in_range  = (n_ext != 32'd0) && (n_ext <= 32'd2048);
        freq_calc = 11'(32'd2048 - n_ext);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            busy_q        <= 1'b0;
            step_q        <= '0;
            dvd_q         <= '0;
            rem_q         <= '0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            pend_duty_q   <= '0;
            O_PERIOD      <= '0;
            O_HIGH        <= '0;
            O_DUTY_CYCLE  <= '0;
            O_FREQUENCY   <= '0;
            O_VALID       <= 1'b0;
            O_RANGE_ERR   <= 1'b0;
            O_TIMEOUT     <= 1'b0;
            O_OVERRUN     <= 1'b0;
        end else begin
            O_VALID     <= 1'b0;
            O_RANGE_ERR <= 1'b0;
            O_TIMEOUT   <= timeout;
            O_OVERRUN   <= overrun;
            if (busy_q) begin
                dvd_q  <= quot_next;
                rem_q  <= rem_next;
                step_q <= step_q - SC_W'(1);
            end
            if (done) begin
                busy_q       <= 1'b0;
                O_PERIOD     <= pend_period_q;
                O_HIGH       <= pend_high_q;
                O_DUTY_CYCLE <= pend_duty_q;
                if (in_range) begin
                    O_FREQUENCY <= freq_calc;
                    O_VALID     <= 1'b1;
                end else begin
                    O_RANGE_ERR <= 1'b1;
                end
            end
            // Accepting a new period overrides the step update above
            if (accept) begin
                busy_q        <= 1'b1;
                step_q        <= STEPS;
                dvd_q         <= {1'b0, cnt_q} + HALF_UNIT;
                rem_q         <= '0;
                pend_period_q <= cnt_q;
                pend_high_q   <= meas_high;
                pend_duty_q   <= duty_calc;
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
// Directed bench for waveform_analyzer: a 16-bit instance for measurement, rounding,
// overrun and reset cases, and an 8-bit instance for the timeout case.
module tb_waveform_analyzer;

    localparam int unsigned PW  = 16;
    localparam int unsigned PW8 = 8;
    localparam int unsigned CPU = 4;
    // Two synchronizer flops, then PERIOD_W+2 cycles of divide latency
    localparam int LAT = 2 + PW + 2;

    logic I_CLK = 1'b0;
    logic I_RESET, wave, wave8, meas_en;

    logic [PW-1:0]  period, high;
    logic [1:0]     duty;
    logic [10:0]    freq;
    logic           valid, rerr, tout, ovr;

    logic [PW8-1:0] period8, high8;
    logic [1:0]     duty8;
    logic [10:0]    freq8;
    logic           valid8, rerr8, tout8, ovr8;

    waveform_analyzer #(.PERIOD_W(PW), .CLKS_PER_UNIT(CPU)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_WAVE(wave), .I_MEASURE_EN(meas_en),
        .O_PERIOD(period), .O_HIGH(high), .O_DUTY_CYCLE(duty), .O_FREQUENCY(freq),
        .O_VALID(valid), .O_RANGE_ERR(rerr), .O_TIMEOUT(tout), .O_OVERRUN(ovr)
    );

    waveform_analyzer #(.PERIOD_W(PW8), .CLKS_PER_UNIT(CPU)) dut8 (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_WAVE(wave8), .I_MEASURE_EN(meas_en),
        .O_PERIOD(period8), .O_HIGH(high8), .O_DUTY_CYCLE(duty8), .O_FREQUENCY(freq8),
        .O_VALID(valid8), .O_RANGE_ERR(rerr8), .O_TIMEOUT(tout8), .O_OVERRUN(ovr8)
    );

    always #5 I_CLK = ~I_CLK;

    int cyc = 0;
    always @(posedge I_CLK) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        int d;
        int f;
        int lat;
    } res_t;

    res_t resq[$];
    res_t mon_rec;
    int   rise_cyc = 0;
    int   valid_cnt = 0, rerr_cnt = 0, ovr_cnt = 0, tout_cnt = 0;
    int   rerr_period = 0, rerr_freq = 0;
    int   valid8_cnt = 0, other8_cnt = 0, tout8_cnt = 0, tout8_cyc = 0;
    int   last8_period = 0, last8_freq = 0;
    int   n_checks = 0, n_errors = 0;

    always @(negedge I_CLK) begin
        if (valid) begin
            mon_rec.p   = int'(period);
            mon_rec.h   = int'(high);
            mon_rec.d   = int'(duty);
            mon_rec.f   = int'(freq);
            mon_rec.lat = cyc - rise_cyc;
            resq.push_back(mon_rec);
            valid_cnt++;
        end
        if (rerr) begin
            rerr_cnt++;
            rerr_period = int'(period);
            rerr_freq   = int'(freq);
        end
        if (ovr)  ovr_cnt++;
        if (tout) tout_cnt++;
        if (valid8) begin
            valid8_cnt++;
            last8_period = int'(period8);
            last8_freq   = int'(freq8);
        end
        if (rerr8 || ovr8) other8_cnt++;
        if (tout8) begin
            tout8_cnt++;
            tout8_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    // sel bit 0 drives the 16-bit instance, bit 1 the 8-bit instance
    task automatic set_wave(input logic v, input int sel);
        if (sel[0]) wave = v;
        if (sel[1]) wave8 = v;
    endtask

    task automatic drive_period(input int h, input int l, input int sel);
        set_wave(1'b1, sel);
        rise_cyc = cyc;
        repeat (h) tick();
        set_wave(1'b0, sel);
        repeat (l) tick();
    endtask

    task automatic rise_hold(input int sel);
        set_wave(1'b1, sel);
        rise_cyc = cyc;
    endtask

    task automatic apply_reset();
        I_RESET = 1'b1;
        wave    = 1'b0;
        wave8   = 1'b0;
        repeat (2) tick();
        I_RESET = 1'b0;
        resq.delete();
        valid_cnt  = 0; rerr_cnt  = 0; ovr_cnt    = 0; tout_cnt = 0;
        valid8_cnt = 0; tout8_cnt = 0; other8_cnt = 0;
    endtask

    task automatic check_rec(input string tag, input int p, input int h, input int d,
                             input int f, input int chk_lat);
        res_t r;
        check_eq({tag, "_avail"}, 32'(resq.size() > 0), 32'd1);
        if (resq.size() > 0) begin
            r = resq.pop_front();
            check_eq({tag, "_period"}, r.p, p);
            check_eq({tag, "_high"}, r.h, h);
            check_eq({tag, "_duty"}, r.d, d);
            check_eq({tag, "_freq"}, r.f, f);
            if (chk_lat != 0) check_eq({tag, "_lat"}, r.lat, LAT);
        end
    endtask

    initial begin
        int c0;
        int waited;
        I_RESET = 1'b1;
        wave    = 1'b0;
        wave8   = 1'b0;
        meas_en = 1'b1;
        repeat (2) tick();
        check_eq("rst_period", period, 0);
        check_eq("rst_high", high, 0);
        check_eq("rst_duty", duty, 0);
        check_eq("rst_freq", freq, 0);
        check_eq("rst_pulses", {valid, rerr, tout, ovr}, 0);

        // 20/20 square wave: one result per closed period
        apply_reset();
        repeat (5) drive_period(20, 20, 1);
        repeat (30) tick();
        check_eq("sq_valid_cnt", valid_cnt, 4);
        for (int i = 0; i < 4; i++) check_rec("sq", 40, 20, 2, 2038, 1);

        // Period 32 with three duty settings
        apply_reset();
        drive_period(4, 28, 1);
        drive_period(8, 24, 1);
        drive_period(24, 8, 1);
        drive_period(4, 28, 1);
        repeat (30) tick();
        check_eq("duty_valid_cnt", valid_cnt, 3);
        check_rec("duty_h4", 32, 4, 0, 2040, 1);
        check_rec("duty_h8", 32, 8, 1, 2040, 1);
        check_rec("duty_h24", 32, 24, 3, 2040, 1);

        // Rounding and the shortest possible period
        apply_reset();
        drive_period(1, 1, 1);
        drive_period(20, 21, 1);
        drive_period(20, 22, 1);
        drive_period(20, 20, 1);
        repeat (30) tick();
        check_eq("rnd_valid_cnt", valid_cnt, 3);
        check_rec("rnd_p2", 2, 1, 2, 2047, 1);
        check_rec("rnd_p41", 41, 20, 2, 2038, 1);
        check_rec("rnd_p42", 42, 20, 2, 2037, 1);

        // n = 2048 gives code 0; n = 2049 is out of range
        apply_reset();
        drive_period(4096, 4096, 1);
        drive_period(4097, 4097, 1);
        drive_period(10, 10, 1);
        repeat (30) tick();
        check_eq("big_valid_cnt", valid_cnt, 1);
        check_rec("big_n2048", 8192, 4096, 2, 0, 1);
        check_eq("big_rerr_cnt", rerr_cnt, 1);
        check_eq("big_rerr_period", rerr_period, 8194);
        check_eq("big_rerr_freq_kept", rerr_freq, 0);

        // Timeout on the 8-bit instance with the wave stuck high
        apply_reset();
        c0 = cyc;
        rise_hold(2);
        waited = 0;
        while (tout8_cnt == 0 && waited < 400) begin
            tick();
            waited++;
        end
        check_eq("to_seen", tout8_cnt, 1);
        check_eq("to_latency", tout8_cyc - c0, 2 + 1 + 255);
        repeat (20) tick();
        check_eq("to_single", tout8_cnt, 1);
        set_wave(1'b0, 2);
        repeat (4) tick();
        drive_period(10, 10, 2);
        drive_period(10, 10, 2);
        repeat (30) tick();
        check_eq("to_restart_valid", valid8_cnt, 1);
        check_eq("to_restart_period", last8_period, 20);
        check_eq("to_restart_freq", last8_freq, 2043);

        // Periods shorter than the divide: every other one is dropped
        apply_reset();
        repeat (6) drive_period(5, 5, 1);
        rise_hold(1);
        repeat (30) tick();
        check_eq("ovr_valid_cnt", valid_cnt, 3);
        check_eq("ovr_cnt", ovr_cnt, 3);
        check_rec("ovr_first", 10, 5, 2, 2045, 0);

        // Reset in the middle of a divide discards the result
        apply_reset();
        drive_period(20, 20, 1);
        drive_period(20, 20, 1);
        rise_hold(1);
        repeat (7) tick();
        check_eq("mid_pre_valid", valid_cnt, 1);
        check_eq("mid_pre_period", period, 40);
        I_RESET = 1'b1;
        tick();
        check_eq("mid_period", period, 0);
        check_eq("mid_high", high, 0);
        check_eq("mid_duty", duty, 0);
        check_eq("mid_freq", freq, 0);
        check_eq("mid_pulses", {valid, rerr, tout, ovr}, 0);
        tick();
        I_RESET = 1'b0;
        repeat (30) tick();
        check_eq("mid_no_valid", valid_cnt, 1);
        check_eq("mid_no_other", rerr_cnt + ovr_cnt + tout_cnt, 0);

        // Measurement disabled: no pulses from either instance
        meas_en = 1'b0;
        apply_reset();
        repeat (5) drive_period(10, 10, 3);
        repeat (300) tick();
        check_eq("dis_pulses", valid_cnt + rerr_cnt + ovr_cnt + tout_cnt, 0);
        check_eq("dis_pulses8", valid8_cnt + other8_cnt + tout8_cnt, 0);
        meas_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
- Measures an incoming square wave and recovers the sound-register encoding that produced it: 11-bit frequency code and 2-bit duty code.
- Inverse of the channel waveform generator.
- Used by the sound loopback bench and by the debug capture path to check channel output against the register writes.
- Runs on the system clock. Back-to-back periods are measured continuously. The frequency code is produced by a sequential divider that runs in parallel with the next measurement.

Parameters:
- PERIOD_W, 24, width of the period and high-time counters and of the divider.
- CLKS_PER_UNIT, 763, I_CLK cycles per 1/131072 s. Frequency code = 2048 - round(period / CLKS_PER_UNIT).

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  synchronous, active-high reset
- I_WAVE  in  1  square wave under test; asynchronous, synchronized internally
- I_MEASURE_EN  in  1  when low, FSM is held in IDLE and no results are produced
- O_PERIOD  out  PERIOD_W  last measured period in clocks
- O_HIGH  out  PERIOD_W  last measured high time in clocks
- O_DUTY_CYCLE  out  2  00=12.5%, 01=25%, 10=50%, 11=75%
- O_FREQUENCY  out  11  recovered frequency code
- O_VALID  out  1  one-cycle pulse; all result outputs update on this cycle
- O_RANGE_ERR  out  1  one-cycle pulse; quotient n was 0 or >2048, O_FREQUENCY unchanged
- O_TIMEOUT  out  1  one-cycle pulse; no rising edge before the counter saturated
- O_OVERRUN  out  1  one-cycle pulse; a period closed while the divider was busy, so that period was dropped

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizer flops 0, divider idle. Reset wins over every other event, including mid-divide: the in-flight result is discarded and no O_VALID is produced.
- Input conditioning: 2-flop synchronizer, then a previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - The constant latency cancels out of all measurements.
- Measurement FSM:
  - IDLE: wait for rise with I_MEASURE_EN=1 -> MEASURE, cnt=1, high_cnt=0, high_open=1.
  - MEASURE: each cycle cnt++.
    - On fall while high_open: high_cnt=cnt, high_open=0.
    - On rise: period=cnt, high=high_cnt, and the period is handed to the divider. cnt restarts at 1 and high_open=1 on the same cycle, so there is no gap between periods.
    - If cnt reaches all-ones: O_TIMEOUT pulse -> IDLE.
    - If I_MEASURE_EN drops: -> IDLE, and any partial period is discarded.
  - A rise with no fall seen (high_open still 1) gives high=period.
- Divider (sequential restoring, unsigned):
  - Dividend = period + CLKS_PER_UNIT/2 (floor), held at PERIOD_W+1 bits. Divisor = CLKS_PER_UNIT.
  - One quotient bit per cycle, PERIOD_W+1 cycles.
  - On completion, n = quotient:
    - If 1 <= n <= 2048: O_FREQUENCY = 2048 - n (11 bits; n=2048 gives 0), O_VALID pulses.
    - Otherwise: O_RANGE_ERR pulses. O_PERIOD, O_HIGH and O_DUTY_CYCLE still update; O_VALID does not pulse.
  - Latency from the closing rise to the O_VALID/O_RANGE_ERR pulse is PERIOD_W+2 cycles.
- Duty classification: computed at hand-off, registered alongside the period, using h16 = high*16 and p = period at PERIOD_W+5 bits.
  - h16 < 3p -> 00
  - h16 < 6p -> 01
  - h16 < 10p -> 10
  - otherwise -> 11
  - Thresholds are the midpoints of 1/8, 2/8, 4/8 and 6/8.
- Overrun: if a rise closes a period while the divider is busy, that period is dropped, O_OVERRUN pulses, and the divider continues with the earlier period. Measurement continues normally.
- Simultaneous events:
  - Timeout and rise on the same cycle: the rise wins.
  - Hand-off and divider completion on the same cycle: the completion is reported and the new period is accepted.

Test Plan:
- CLKS_PER_UNIT=4, PERIOD_W=16. Wave 20 high / 20 low, repeated -> O_PERIOD=40, O_HIGH=20, O_DUTY_CYCLE=10, O_FREQUENCY=2038 (11'h7F6), O_VALID once per period after the first, exactly 18 cycles after the closing rise.
- CLKS_PER_UNIT=4. Period 32 with high 4, then 8, then 24 -> O_DUTY_CYCLE 00, 01, 11; O_FREQUENCY=2040 each time.
- Rounding, CLKS_PER_UNIT=4: period 41 -> 2038; period 42 -> 2037; period 1 -> O_RANGE_ERR (n=0).
- PERIOD_W=8, I_WAVE held high after one rise -> O_TIMEOUT pulse 255 cycles after entering MEASURE, then FSM in IDLE; the next rise restarts measurement.
- PERIOD_W=16. Periods of 10 clocks (shorter than the divider latency) -> O_OVERRUN pulses for the dropped periods; the first accepted period still yields a correct O_VALID result.
- I_RESET asserted 5 cycles into a divide -> no O_VALID, all outputs 0 the next cycle. I_MEASURE_EN low -> no pulses of any kind for any I_WAVE activity.
